// File: rtl/data_mem_responder.sv
// Memory-side responder for the MEM-stage data request interface: accepts one
// load/store at a time, performs it after LATENCY cycles and holds the response.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_cmd,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        cmd_q;
  logic [31:0] addr_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept;
  logic             resp_done;
  logic             enter_resp;
  logic             acc_cmd;
  logic [31:0]      acc_addr;
  logic [3:0]       acc_mask;
  logic [31:0]      acc_wdata;
  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;

  assign accept     = req_valid & req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_done  = resp_valid & resp_ready;

  // With LATENCY==1 the access happens on the accept edge, before the capture registers load.
  assign acc_cmd   = (state_q == S_IDLE) ? req_cmd   : cmd_q;
  assign acc_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign acc_mask  = (state_q == S_IDLE) ? req_mask  : mask_q;
  assign acc_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

  assign acc_err = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
  assign acc_idx = acc_addr[2 +: IDX_W];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_ready  <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cmd_q      <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Registered so it rises one edge after reset and stays low on the response handshake edge.
      req_ready <= (state_d == S_IDLE);
      if (accept) begin
        cmd_q   <= req_cmd;
        addr_q  <= req_addr;
        mask_q  <= req_mask;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        resp_err   <= acc_err;
        resp_rdata <= (!acc_cmd && !acc_err) ? mem[acc_idx] : '0;
      end else if (resp_done) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end

  // NOTE: the word array is deliberately not reset; contents persist across rst and
  // a reset branch here would prevent mapping onto a byte-enabled RAM.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && acc_cmd && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 4) driven with directed and
// random load/store traffic, compared against a word-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_cmd;
  logic [31:0] req_addr  [2];
  logic [3:0]  req_mask  [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_err;

  logic [31:0] model [2][DEPTH];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    ((g == 0) ? 2 : 4)
    ) dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_cmd   (req_cmd[g]),
      .req_addr  (req_addr[g]),
      .req_mask  (req_mask[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  // Reference: word array with byte-lane writes; range/alignment rules applied arithmetically.
  task automatic model_access(input int d, input logic cmd, input logic [31:0] addr,
                              input logic [3:0] mask, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
    int unsigned idx;
    err   = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
    rdata = '0;
    idx   = addr / 4;
    if (!err) begin
      if (cmd) begin
        for (int b = 0; b < 4; b++) begin
          if (mask[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end else begin
        rdata = model[d][idx];
      end
    end
  endtask

  task automatic drive(input int d, input logic cmd, input logic [31:0] addr,
                       input logic [3:0] mask, input logic [31:0] wdata);
    req_cmd[d]   = cmd;
    req_addr[d]  = addr;
    req_mask[d]  = mask;
    req_wdata[d] = wdata;
  endtask

  task automatic rand_req(output logic cmd, output logic [31:0] addr,
                          output logic [3:0] mask, output logic [31:0] wdata);
    int unsigned sel = $urandom_range(0, 9);
    int unsigned w   = $urandom_range(0, 15);
    cmd   = 1'($urandom_range(0, 1));
    mask  = 4'($urandom);
    wdata = $urandom;
    if (sel <= 6)      addr = 32'(w * 4);
    else if (sel == 7) addr = 32'(w * 4 + $urandom_range(1, 3));
    else if (sel == 8) addr = 32'h1000 + 32'(w * 4);
    else               addr = $urandom | 32'h8000_0000;
  endtask

  // Called and returns at a negedge; checks latency, hold stability and handshake.
  task automatic txn(input int d, input logic cmd, input logic [31:0] addr,
                     input logic [3:0] mask, input logic [31:0] wdata,
                     input int hold, output logic [31:0] got);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          w;
    got = '0;
    model_access(d, cmd, addr, mask, wdata, exp_rdata, exp_err);
    drive(d, cmd, addr, mask, wdata);
    req_valid[d] = 1'b1;
    w = 0;
    while (req_ready[d] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_bit("accept_wait", req_ready[d], 1'b1);
    if (req_ready[d] !== 1'b1) begin
      req_valid[d] = 1'b0;
      return;
    end
    for (int i = 1; i <= lat(d); i++) begin
      @(negedge clk);
      req_valid[d] = 1'b0;
      check_bit("busy_req_ready", req_ready[d], 1'b0);
      check_bit("resp_valid_timing", resp_valid[d], i == lat(d));
    end
    got = resp_rdata[d];
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(negedge clk);
        check_bit("hold_resp_valid", resp_valid[d], 1'b1);
        check_bit("hold_req_ready", req_ready[d], 1'b0);
      end
      check("resp_rdata", resp_rdata[d], exp_rdata);
      check_bit("resp_err", resp_err[d], exp_err);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check_bit("done_resp_valid", resp_valid[d], 1'b0);
    check("done_rdata", resp_rdata[d], 32'h0);
    check_bit("done_err", resp_err[d], 1'b0);
    check_bit("done_req_ready", req_ready[d], 1'b1);
  endtask

  // req_valid and resp_ready held high: accepts must be LATENCY+1 cycles apart.
  task automatic b2b(input int d, input int k);
    logic [32:0] exp_q [$];
    logic [32:0] ex;
    logic        cmd;
    logic [31:0] addr, wdata, er;
    logic [3:0]  mask;
    logic        e;
    int          n_acc = 0;
    int          n_resp = 0;
    int          cyc = 0;
    int          prev = 0;
    bit          acc_now;
    rand_req(cmd, addr, mask, wdata);
    drive(d, cmd, addr, mask, wdata);
    req_valid[d]  = 1'b1;
    resp_ready[d] = 1'b1;
    while ((n_acc < k || n_resp < n_acc) && cyc < 400) begin
      acc_now = 1'b0;
      if (resp_valid[d] === 1'b1) begin
        check_bit("b2b_resp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          ex = exp_q.pop_front();
          check("b2b_rdata", resp_rdata[d], ex[31:0]);
          check_bit("b2b_err", resp_err[d], ex[32]);
        end
        n_resp++;
      end
      if (req_valid[d] === 1'b1 && req_ready[d] === 1'b1) begin
        if (n_acc > 0) check("b2b_spacing", 32'(cyc - prev), 32'(lat(d) + 1));
        prev = cyc;
        model_access(d, cmd, addr, mask, wdata, er, e);
        exp_q.push_back({e, er});
        n_acc++;
        acc_now = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        if (n_acc < k) begin
          rand_req(cmd, addr, mask, wdata);
          drive(d, cmd, addr, mask, wdata);
        end else begin
          req_valid[d] = 1'b0;
        end
      end
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'(k));
    check("b2b_responses", 32'(n_resp), 32'(k));
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] got;
    logic [31:0] prior;
    logic        cmd;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;

    rst        = 2'b00;
    req_valid  = 2'b00;
    req_cmd    = 2'b00;
    resp_ready = 2'b00;
    for (int d = 0; d < 2; d++) drive(d, 1'b0, 32'h0, 4'h0, 32'h0);

    // Reset state, then ready one edge after release.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_bit("rst_req_ready", req_ready[d], 1'b0);
      check_bit("rst_resp_valid", resp_valid[d], 1'b0);
      check_bit("rst_resp_err", resp_err[d], 1'b0);
      check("rst_resp_rdata", resp_rdata[d], 32'h0);
    end
    rst = 2'b11;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_bit("release_req_ready", req_ready[d], 1'b1);

    // Give words 0..15 known contents in both instances.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) txn(d, 1'b1, 32'(w * 4), 4'hF, $urandom, 0, got);
    end

    // Full store then load.
    txn(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, got);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, got);
    check("t1_load", got, 32'hDEADBEEF);

    // Partial store, then empty-mask store.
    txn(0, 1'b1, 32'h10, 4'b0011, 32'h00001234, 1, got);
    txn(0, 1'b0, 32'h10, 4'hF, 32'hFFFF_FFFF, 0, got);
    check("t2_partial", got, 32'hDEAD1234);
    txn(0, 1'b1, 32'h10, 4'b0000, 32'h5555_5555, 0, got);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, got);
    check("t2_empty_mask", got, 32'hDEAD1234);

    // Misaligned and out-of-range accesses.
    txn(0, 1'b0, 32'h12, 4'hF, 32'h0, 0, got);
    txn(0, 1'b1, 32'h12, 4'hF, 32'h0BAD_0BAD, 0, got);
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 0, got);
    check("t3_after_misaligned", got, 32'hDEAD1234);
    prior = model[0][0];
    txn(0, 1'b1, 32'h1000, 4'hF, ~prior, 0, got);
    txn(0, 1'b0, 32'h0, 4'h0, 32'h0, 0, got);
    check("t3_no_wrap", got, prior);

    // Response held five cycles under backpressure.
    txn(0, 1'b0, 32'h10, 4'h0, 32'h0, 5, got);

    // Reset two cycles into a LATENCY=4 store: dropped, no response, no write.
    prior = model[1][8];
    drive(1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D);
    req_valid[1] = 1'b1;
    check_bit("t5_ready_at_accept", req_ready[1], 1'b1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    check_bit("t5_busy", req_ready[1], 1'b0);
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_bit("t5_rst_resp_valid", resp_valid[1], 1'b0);
      check_bit("t5_rst_req_ready", req_ready[1], 1'b0);
    end
    rst[1] = 1'b1;
    @(negedge clk);
    check_bit("t5_release_ready", req_ready[1], 1'b1);
    check_bit("t5_no_response", resp_valid[1], 1'b0);
    txn(1, 1'b0, 32'h20, 4'h0, 32'h0, 0, got);
    check("t5_prior_value", got, prior);

    // Back-to-back throughput on both latencies.
    b2b(0, 8);
    b2b(1, 8);

    // Random traffic with random backpressure.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        rand_req(cmd, addr, mask, wdata);
        txn(d, cmd, addr, mask, wdata, int'($urandom_range(0, 3)), got);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
